// File: rtl/tlk2711_pkg.sv
// tlk2711_pkg
//   Shared definitions for the TLK2711 link controller: controller states,
//   frame-generator phases, i_mode encodings and the 8b/10b control words
//   placed on the 16-bit TX bus (upper byte -> tkmsb, lower byte -> tklsb).
package tlk2711_pkg;

    typedef enum logic [2:0] {
        PWRUP,
        IDLE,
        SYNC,
        SEND,
        PRBS,
        RAW,
        STOPACK
    } state_t;

    typedef enum logic [1:0] {
        PH_SOF,
        PH_PAY,
        PH_EOF,
        PH_GAP
    } phase_t;

    localparam logic [1:0] MODE_FRAMED = 2'd0;
    localparam logic [1:0] MODE_LOOP   = 2'd1;
    localparam logic [1:0] MODE_PRBS   = 2'd2;
    localparam logic [1:0] MODE_RAW    = 2'd3;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] D5_6  = 8'hC5;
    localparam logic [7:0] K27_7 = 8'hFB;
    localparam logic [7:0] K29_7 = 8'hFD;

    localparam logic [15:0] IDLE_W = {D5_6,  K28_5};
    localparam logic [15:0] SOF_W  = {K27_7, K28_5};
    localparam logic [15:0] EOF_W  = {K29_7, K28_5};

    // K flag pairs, bit 1 = tkmsb, bit 0 = tklsb
    localparam logic [1:0] K_NONE = 2'b00;
    localparam logic [1:0] K_IDLE = 2'b01;
    localparam logic [1:0] K_CTRL = 2'b11;

endpackage

// File: rtl/tlk2711_link_ctrl_frame_gen.sv
// tlk2711_frame_gen
//   SOF / payload / EOF / gap sequencer and 16-bit payload counter.
//   Ports:
//     clk, rst     clock, asynchronous active-high reset
//     run          emit the current word this edge and advance
//     clear        (only when not running) zero the payload counter
//     stop_req     stop pending: hold in the gap rather than open a new frame
//     raw          raw-counter mode: counter word every cycle, no framing
//     word, k      word to emit this edge and its K flags {msb, lsb}
//     frame_done   no frame in progress (gap or about to send SOF)
//   When run is low the phase rewinds to SOF but the counter is kept, so a
//   re-sync resumes the payload sequence where it left off.
module tlk2711_frame_gen
    import tlk2711_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 256,
    parameter int unsigned GAP_CYC   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        clear,
    input  logic        stop_req,
    input  logic        raw,
    output logic [15:0] word,
    output logic [1:0]  k,
    output logic        frame_done
);

    phase_t      phase;
    logic [15:0] cnt;
    logic [31:0] idx;

    always_comb begin
        word = IDLE_W;
        k    = K_IDLE;
        if (raw) begin
            word = cnt;
            k    = K_NONE;
        end else begin
            case (phase)
                PH_SOF: begin word = SOF_W; k = K_CTRL; end
                PH_PAY: begin word = cnt;   k = K_NONE; end
                PH_EOF: begin word = EOF_W; k = K_CTRL; end
                default: begin word = IDLE_W; k = K_IDLE; end
            endcase
        end
    end

    assign frame_done = (phase == PH_GAP) || (phase == PH_SOF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= PH_SOF;
            cnt   <= '0;
            idx   <= '0;
        end else if (run) begin
            if (raw) begin
                cnt <= cnt + 16'd1;
            end else begin
                case (phase)
                    PH_SOF: begin
                        phase <= PH_PAY;
                        idx   <= '0;
                    end
                    PH_PAY: begin
                        cnt <= cnt + 16'd1;
                        if (idx == FRAME_LEN - 1) begin
                            phase <= PH_EOF;
                        end else begin
                            idx <= idx + 32'd1;
                        end
                    end
                    PH_EOF: begin
                        phase <= PH_GAP;
                        idx   <= '0;
                    end
                    default: begin
                        if (!stop_req) begin
                            if (idx == GAP_CYC - 1) begin
                                phase <= PH_SOF;
                            end else begin
                                idx <= idx + 32'd1;
                            end
                        end
                    end
                endcase
            end
        end else begin
            phase <= PH_SOF;
            idx   <= '0;
            if (clear) begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/tlk2711_link_ctrl.sv
// tlk2711_link_ctrl
//   TLK2711 SERDES link controller: power-up sequencing, idle, receive-sync
//   wait, framed payload transmission, PRBS and raw-counter test modes.
//   Ports:
//     clk, rst                    clk_80, asynchronous active-high reset
//     i_start, i_stop             VIO levels; rising edges start / stop a run
//     i_mode                      0 framed, 1 framed+loopback, 2 PRBS, 3 raw
//     i_rx_sync                   RX comma lock (already in clk domain)
//     o_stop_ack                  one-cycle pulse when a stop completes
//     o_txd, o_tkmsb, o_tklsb     TX word and per-byte K flags
//     o_enable .. o_testen        TLK2711 control pins
//     o_link_up, o_busy           status
//   All pin outputs are registered from the next state, so a word and the
//   state that produced it appear on the bus in the same cycle.
module tlk2711_link_ctrl
    import tlk2711_pkg::*;
#(
    parameter int unsigned PWRUP_CYC = 1000,
    parameter int unsigned SYNC_CYC  = 16,
    parameter int unsigned FRAME_LEN = 256,
    parameter int unsigned GAP_CYC   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [1:0]  i_mode,
    input  logic        i_stop,
    input  logic        i_rx_sync,
    output logic        o_stop_ack,
    output logic [15:0] o_txd,
    output logic        o_tkmsb,
    output logic        o_tklsb,
    output logic        o_enable,
    output logic        o_lckrefn,
    output logic        o_loopen,
    output logic        o_prbsen,
    output logic        o_testen,
    output logic        o_link_up,
    output logic        o_busy
);

    state_t      state, next_state;
    logic [1:0]  mode_q, mode_nx;
    logic [31:0] pwr_cnt;
    logic [31:0] sync_cnt;
    logic        start_d, stop_d, start_edge, stop_edge;
    logic        stop_pend, sync_lost;
    logic        sync_hit;
    logic        fg_run, fg_clear, fg_raw, fg_stop, fg_done;
    logic [15:0] fg_word;
    logic [1:0]  fg_k;

    assign o_testen = 1'b0;

    // Edge pulses are registered, so the FSM reacts one cycle after the
    // cycle in which the level rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_d    <= 1'b0;
            stop_d     <= 1'b0;
            start_edge <= 1'b0;
            stop_edge  <= 1'b0;
        end else begin
            start_d    <= i_start;
            stop_d     <= i_stop;
            start_edge <= i_start & ~start_d;
            stop_edge  <= i_stop & ~stop_d;
        end
    end

    assign sync_hit = (state == SYNC) && i_rx_sync && (sync_cnt == SYNC_CYC - 1);

    always_comb begin
        next_state = state;
        mode_nx    = mode_q;
        case (state)
            PWRUP: begin
                if (pwr_cnt == PWRUP_CYC - 1) next_state = IDLE;
            end
            IDLE: begin
                // stop wins over a coincident start
                if (stop_edge) begin
                    next_state = STOPACK;
                end else if (start_edge) begin
                    mode_nx = i_mode;
                    case (i_mode)
                        MODE_PRBS: next_state = PRBS;
                        MODE_RAW:  next_state = RAW;
                        default:   next_state = SYNC;
                    endcase
                end
            end
            SYNC: begin
                if (stop_edge)     next_state = STOPACK;
                else if (sync_hit) next_state = SEND;
            end
            SEND: begin
                // only leave between frames; a frame always runs through EOF
                if (fg_done) begin
                    if (stop_pend || stop_edge)        next_state = STOPACK;
                    else if (sync_lost || !i_rx_sync)  next_state = SYNC;
                end
            end
            PRBS, RAW: begin
                if (stop_edge) next_state = STOPACK;
            end
            STOPACK: next_state = IDLE;
            default: next_state = PWRUP;
        endcase
    end

    assign fg_run   = (next_state == SEND) || (next_state == RAW);
    assign fg_raw   = (next_state == RAW);
    assign fg_clear = next_state inside {PWRUP, IDLE, STOPACK};
    assign fg_stop  = stop_pend | stop_edge;

    tlk2711_frame_gen #(
        .FRAME_LEN (FRAME_LEN),
        .GAP_CYC   (GAP_CYC)
    ) u_frame_gen (
        .clk        (clk),
        .rst        (rst),
        .run        (fg_run),
        .clear      (fg_clear),
        .stop_req   (fg_stop),
        .raw        (fg_raw),
        .word       (fg_word),
        .k          (fg_k),
        .frame_done (fg_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= PWRUP;
            mode_q     <= MODE_FRAMED;
            pwr_cnt    <= '0;
            sync_cnt   <= '0;
            stop_pend  <= 1'b0;
            sync_lost  <= 1'b0;
            o_txd      <= '0;
            o_tkmsb    <= 1'b0;
            o_tklsb    <= 1'b0;
            o_enable   <= 1'b0;
            o_lckrefn  <= 1'b0;
            o_loopen   <= 1'b0;
            o_prbsen   <= 1'b0;
            o_stop_ack <= 1'b0;
            o_link_up  <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            state  <= next_state;
            mode_q <= mode_nx;

            if (state == PWRUP) pwr_cnt <= pwr_cnt + 32'd1;

            if (state == SYNC && next_state == SYNC)
                sync_cnt <= i_rx_sync ? sync_cnt + 32'd1 : '0;
            else
                sync_cnt <= '0;

            stop_pend <= (state == SEND) && (next_state == SEND) && (stop_pend | stop_edge);
            sync_lost <= (state == SEND) && (next_state == SEND) && (sync_lost | ~i_rx_sync);

            // link-up drops on the first cycle sync is seen low in SEND
            o_link_up <= (next_state == SEND) &&
                         !((state == SEND) && (sync_lost || !i_rx_sync));

            o_enable   <= (next_state != PWRUP);
            o_lckrefn  <= (next_state != PWRUP);
            o_busy     <= (next_state != PWRUP) && (next_state != IDLE);
            o_loopen   <= 1'b0;
            o_prbsen   <= 1'b0;
            o_stop_ack <= 1'b0;
            o_txd      <= IDLE_W;
            {o_tkmsb, o_tklsb} <= K_IDLE;

            case (next_state)
                PWRUP: begin
                    o_txd <= '0;
                    {o_tkmsb, o_tklsb} <= K_NONE;
                end
                SYNC: begin
                    o_loopen <= (mode_nx == MODE_LOOP);
                end
                SEND: begin
                    o_loopen <= (mode_nx == MODE_LOOP);
                    o_txd    <= fg_word;
                    {o_tkmsb, o_tklsb} <= fg_k;
                end
                PRBS: begin
                    o_prbsen <= 1'b1;
                    o_txd    <= '0;
                    {o_tkmsb, o_tklsb} <= K_NONE;
                end
                RAW: begin
                    o_txd <= fg_word;
                    {o_tkmsb, o_tklsb} <= K_NONE;
                end
                STOPACK: begin
                    o_stop_ack <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tlk2711_link_ctrl.sv
// tb_tlk2711_link_ctrl
//   Directed self-checking bench for tlk2711_link_ctrl with PWRUP_CYC=10,
//   SYNC_CYC=16, FRAME_LEN=256, GAP_CYC=4. Outputs are sampled 1 time unit
//   after each rising clock edge; expected values are hand-derived.
module tb_tlk2711_link_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start, i_stop, i_rx_sync;
    logic [1:0]  i_mode;
    logic        o_stop_ack, o_tkmsb, o_tklsb, o_enable, o_lckrefn;
    logic        o_loopen, o_prbsen, o_testen, o_link_up, o_busy;
    logic [15:0] o_txd;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    tlk2711_link_ctrl #(
        .PWRUP_CYC (10),
        .SYNC_CYC  (16),
        .FRAME_LEN (256),
        .GAP_CYC   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_mode     (i_mode),
        .i_stop     (i_stop),
        .i_rx_sync  (i_rx_sync),
        .o_stop_ack (o_stop_ack),
        .o_txd      (o_txd),
        .o_tkmsb    (o_tkmsb),
        .o_tklsb    (o_tklsb),
        .o_enable   (o_enable),
        .o_lckrefn  (o_lckrefn),
        .o_loopen   (o_loopen),
        .o_prbsen   (o_prbsen),
        .o_testen   (o_testen),
        .o_link_up  (o_link_up),
        .o_busy     (o_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_txd"}, o_txd, 16'h0000);
        chk({tag, "_k"}, {o_tkmsb, o_tklsb}, 2'b00);
        chk({tag, "_pins"}, {o_enable, o_lckrefn, o_loopen, o_prbsen, o_testen}, 5'b00000);
        chk({tag, "_status"}, {o_stop_ack, o_link_up, o_busy}, 3'b000);
    endtask

    initial begin
        int found;
        logic [15:0] prev;

        rst = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_rx_sync = 1'b0; i_mode = 2'd0;
        #2;
        chk_reset_vals("rst");
        tick(); tick();
        rst = 1'b0;

        // power-up: pins rise on the 10th edge after release
        repeat (9) tick();
        chk("pwrup_en_low", {o_enable, o_lckrefn}, 2'b00);
        tick();
        chk("pwrup_en_high", {o_enable, o_lckrefn}, 2'b11);
        chk("idle_word", o_txd, 16'hC5BC);
        chk("idle_k", {o_tkmsb, o_tklsb}, 2'b01);
        chk("idle_busy", o_busy, 1'b0);
        tick(); tick();

        // mode 0, sync held high: SOF 18 cycles after start rises
        i_mode = 2'd0; i_rx_sync = 1'b1; i_start = 1'b1;
        tick();
        chk("m0_still_idle", o_busy, 1'b0);
        tick();
        chk("m0_sync_busy", o_busy, 1'b1);
        chk("m0_sync_word", o_txd, 16'hC5BC);
        chk("m0_loopen", o_loopen, 1'b0);
        repeat (15) tick();
        chk("m0_link_pre", o_link_up, 1'b0);
        tick();
        chk("m0_link_up", o_link_up, 1'b1);
        chk("m0_sof", o_txd, 16'hFBBC);
        chk("m0_sof_k", {o_tkmsb, o_tklsb}, 2'b11);
        i_start = 1'b0;
        for (int i = 0; i < 256; i++) begin
            tick();
            chk("m0_pay", {o_tkmsb, o_tklsb, o_txd}, {2'b00, 16'(i)});
        end
        tick();
        chk("m0_eof", {o_tkmsb, o_tklsb, o_txd}, {2'b11, 16'hFDBC});
        for (int g = 0; g < 4; g++) begin
            tick();
            chk("m0_gap", {o_tkmsb, o_tklsb, o_txd}, {2'b01, 16'hC5BC});
        end
        tick();
        chk("m0_sof2", o_txd, 16'hFBBC);
        for (int i = 256; i < 261; i++) begin
            tick();
            chk("m0_pay2", o_txd, 16'(i));
        end

        // sync drop mid-frame: link drops next cycle, frame completes
        i_rx_sync = 1'b0;
        tick();
        chk("loss_link_down", o_link_up, 1'b0);
        chk("loss_pay_cont", o_txd, 16'd261);
        i_rx_sync = 1'b1;
        for (int i = 262; i < 512; i++) begin
            tick();
            chk("loss_pay", o_txd, 16'(i));
        end
        tick();
        chk("loss_eof", o_txd, 16'hFDBC);
        chk("loss_link_eof", o_link_up, 1'b0);
        tick();
        chk("resync_idle", o_txd, 16'hC5BC);
        chk("resync_busy", o_busy, 1'b1);

        // glitch at sync count 10 restarts the count
        repeat (10) tick();
        i_rx_sync = 1'b0;
        tick();
        i_rx_sync = 1'b1;
        repeat (15) tick();
        chk("glitch_link_pre", o_link_up, 1'b0);
        chk("glitch_idle_pre", o_txd, 16'hC5BC);
        tick();
        chk("glitch_link_up", o_link_up, 1'b1);
        chk("glitch_sof", o_txd, 16'hFBBC);
        tick();
        chk("resume_count", o_txd, 16'd512);

        // stop mode 0 run: ack follows EOF (bounded wait)
        i_stop = 1'b1;
        found = 0;
        prev = o_txd;
        for (int n = 0; n < 400 && found == 0; n++) begin
            prev = o_txd;
            tick();
            if (o_stop_ack === 1'b1) found = 1;
        end
        chk("m0_ack_seen", found, 1);
        chk("m0_pre_ack_eof", prev, 16'hFDBC);
        tick();
        chk("m0_ack_width", o_stop_ack, 1'b0);
        chk("m0_busy_drop", o_busy, 1'b0);
        i_stop = 1'b0;
        tick(); tick();

        // mode 1, stop at payload word 5
        i_mode = 2'd1; i_start = 1'b1;
        tick();
        chk("m1_loopen_idle", o_loopen, 1'b0);
        tick();
        chk("m1_loopen_sync", o_loopen, 1'b1);
        repeat (16) tick();
        chk("m1_sof", o_txd, 16'hFBBC);
        i_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("m1_pay", o_txd, 16'(i));
        end
        i_stop = 1'b1;
        for (int i = 6; i < 256; i++) begin
            tick();
            chk("m1_pay_after_stop", {o_stop_ack, o_txd}, {1'b0, 16'(i)});
        end
        tick();
        chk("m1_eof", o_txd, 16'hFDBC);
        chk("m1_eof_loopen", o_loopen, 1'b1);
        chk("m1_eof_noack", o_stop_ack, 1'b0);
        tick();
        chk("m1_ack", o_stop_ack, 1'b1);
        chk("m1_ack_word", o_txd, 16'hC5BC);
        chk("m1_ack_busy", o_busy, 1'b1);
        tick();
        chk("m1_ack_off", o_stop_ack, 1'b0);
        chk("m1_idle_busy", o_busy, 1'b0);
        chk("m1_idle_loopen", o_loopen, 1'b0);
        i_stop = 1'b0;
        tick(); tick();

        // mode 2, simultaneous start+stop: stop wins
        i_mode = 2'd2; i_start = 1'b1; i_stop = 1'b1;
        tick();
        chk("m2_both_noack", o_stop_ack, 1'b0);
        tick();
        chk("m2_both_ack", {o_stop_ack, o_prbsen}, 2'b10);
        tick();
        chk("m2_both_after", {o_stop_ack, o_prbsen, o_busy}, 3'b000);
        i_start = 1'b0; i_stop = 1'b0;
        tick(); tick();
        i_start = 1'b1;
        tick(); tick();
        chk("m2_prbsen", o_prbsen, 1'b1);
        chk("m2_txd", {o_tkmsb, o_tklsb, o_txd}, 18'h0);
        chk("m2_busy", o_busy, 1'b1);
        i_start = 1'b0;
        tick(); tick();
        i_stop = 1'b1;
        tick();
        chk("m2_stop_pre", {o_prbsen, o_stop_ack}, 2'b10);
        tick();
        chk("m2_stop_ack", {o_prbsen, o_stop_ack}, 2'b01);
        i_stop = 1'b0;
        tick();
        chk("m2_idle", {o_stop_ack, o_busy}, 2'b00);

        // mode 3 raw counter across the 16-bit wrap
        i_mode = 2'd3; i_start = 1'b1;
        tick();
        chk("m3_idle", o_txd, 16'hC5BC);
        tick();
        chk("m3_first", {o_tkmsb, o_tklsb, o_txd}, 18'h0);
        chk("m3_busy", o_busy, 1'b1);
        i_start = 1'b0;
        tick();
        chk("m3_second", o_txd, 16'd1);
        repeat (65534) tick();
        chk("m3_ffff", {o_tkmsb, o_tklsb, o_txd}, {2'b00, 16'hFFFF});
        tick();
        chk("m3_wrap", {o_tkmsb, o_tklsb, o_txd}, {2'b00, 16'h0000});
        tick();
        chk("m3_after_wrap", o_txd, 16'd1);
        chk("m3_nolink", o_link_up, 1'b0);

        // asynchronous reset mid-run
        #2 rst = 1'b1;
        #1;
        chk_reset_vals("arst");
        #2 rst = 1'b0;
        repeat (9) tick();
        chk("arst_pwrup_low", {o_enable, o_lckrefn, o_busy}, 3'b000);
        tick();
        chk("arst_pwrup_high", {o_enable, o_lckrefn}, 2'b11);
        chk("arst_idle_word", o_txd, 16'hC5BC);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
